// File: rtl/ps2_frame_rx_if.sv
// Scan-code byte interface between the PS/2 receiver FIFO (master) and its consumer (slave).
// PS2_PARITY_CHECK_EN adds the parity_err pulse to the bundle.
interface ps2_frame_rx_if;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
`ifdef PS2_PARITY_CHECK_EN
  logic       parity_err;

  modport master (
    input  nextdata_n,
    output data,
    output ready,
    output overflow,
    output parity_err
  );

  modport slave (
    output nextdata_n,
    input  data,
    input  ready,
    input  overflow,
    input  parity_err
  );
`else
  modport master (
    input  nextdata_n,
    output data,
    output ready,
    output overflow
  );

  modport slave (
    output nextdata_n,
    input  data,
    input  ready,
    input  overflow
  );
`endif
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver feeding a show-ahead byte FIFO.
// Optional odd-parity rejection and parity_err pulse: define PS2_PARITY_CHECK_EN.
module ps2_frame_rx #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_frame_rx_if.master bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYC);
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned LAST_BIT = 10;
  localparam int unsigned PAR_BIT  = 9;
`ifdef PS2_PARITY_CHECK_EN
  localparam int unsigned FRAME_W = 10;
`else
  localparam int unsigned FRAME_W = 9;
`endif

  logic [2:0]         r_ck;
  logic [1:0]         r_dsync;
  logic [BIT_W-1:0]   r_bitcnt;
  logic [FRAME_W-1:0] r_frame;
  logic [CNT_W-1:0]   r_tmo;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [7:0]         r_mem [DEPTH];
  logic               r_overflow;
`ifdef PS2_PARITY_CHECK_EN
  logic               r_parity_err;
`endif

  logic       w_fe;
  logic       w_dsync;
  logic       w_last;
  logic       w_shift;
  logic       w_framing_ok;
  logic       w_push;
  logic       w_pop;
  logic       w_wr;
  logic       w_empty;
  logic       w_full;
  logic       w_tmo_hit;
  logic [7:0] w_byte;

  // Frame layout after the shifts: [0]=start, [8:1]=data LSB-first, [9]=parity; stop is live dsync.
  assign w_fe         = (r_ck[2:1] == 2'b10);
  assign w_dsync      = r_dsync[1];
  assign w_last       = w_fe && (r_bitcnt == BIT_W'(LAST_BIT));
  assign w_byte       = r_frame[8:1];
  assign w_framing_ok = !r_frame[0] && w_dsync;
  assign w_tmo_hit    = (r_bitcnt != '0) && (r_tmo == CNT_W'(TIMEOUT_CYC - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic w_parity_ok;
  assign w_parity_ok = ^r_frame[9:1];
  assign w_shift     = w_fe && (r_bitcnt < BIT_W'(LAST_BIT));
  assign w_push      = w_last && w_framing_ok && w_parity_ok;
`else
  // Parity bit is sampled but not stored when it is not checked.
  assign w_shift     = w_fe && (r_bitcnt < BIT_W'(LAST_BIT)) && (r_bitcnt != BIT_W'(PAR_BIT));
  assign w_push      = w_last && w_framing_ok;
`endif

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_pop   = !bus.nextdata_n && !w_empty;
  // A push into a full FIFO lands in the slot being popped that same edge.
  assign w_wr    = w_push && (!w_full || w_pop);

  // Synchronisers, bit assembly, timeout and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_ck       <= 3'b111;
      r_dsync    <= 2'b11;
      r_bitcnt   <= '0;
      r_frame    <= '0;
      r_tmo      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ck    <= {r_ck[1:0], ps2_clk};
      r_dsync <= {r_dsync[0], ps2_data};

      if (w_shift) begin
        r_frame <= {w_dsync, r_frame[FRAME_W-1:1]};
      end

      if (w_fe) begin
        r_bitcnt <= w_last ? '0 : r_bitcnt + BIT_W'(1);
      end else if (w_tmo_hit) begin
        r_bitcnt <= '0;
      end

      if (w_fe || (r_bitcnt == '0) || w_tmo_hit) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + CNT_W'(1);
      end

      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage array carries no reset; empty FIFO masks its contents.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= w_byte;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // One-cycle pulse for frames whose only defect is parity.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_last && w_framing_ok && !w_parity_ok;
    end
  end

  assign bus.parity_err = r_parity_err;
`endif

  assign bus.data     = w_empty ? 8'h00 : r_mem[r_rptr[ADDR_W-1:0]];
  assign bus.ready    = !w_empty;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: bit-banged PS/2 frames, queue scoreboard for FIFO bytes.
// Build with PS2_PARITY_CHECK_EN defined to exercise the parity rejection path.
module tb_ps2_frame_rx;

  localparam int unsigned HALF_PER = 30;
  localparam int unsigned TMO      = 300;

  logic clk;
  logic clrn;
  logic ps2_clk;
  logic ps2_data;

  ps2_frame_rx_if bus ();

  ps2_frame_rx #(
    .ADDR_W      (3),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_bad;
  logic [7:0] q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
  endtask

  // mode 0: plain, 1: latency check, 2: pop on the push edge, 3: parity_err pulse check
  task automatic send_frame(input logic [7:0] b, input int nbits, input logic par_flip,
                            input logic stop_v, input int mode);
    logic [10:0] f;
    int          remain;
    logic [7:0]  exp_b;
    f = {stop_v, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF_PER) tick();
      ps2_clk = 1'b0;
      remain  = HALF_PER;
      if (i == 10 && mode == 1) begin
        tick();
        tick();
        check_eq("lat_not_yet", 32'(bus.ready), 32'd0);
        tick();
        check_eq("lat_ready", 32'(bus.ready), 32'd1);
        check_eq("lat_data", 32'(bus.data), 32'(b));
        remain = HALF_PER - 3;
      end else if (i == 10 && mode == 2) begin
        tick();
        tick();
        bus.nextdata_n = 1'b0;
        exp_b = q.pop_front();
        check_eq("full_rdy", 32'(bus.ready), 32'd1);
        check_eq("full_head", 32'(bus.data), 32'(exp_b));
        tick();
        bus.nextdata_n = 1'b1;
        remain = HALF_PER - 3;
      end
`ifdef PS2_PARITY_CHECK_EN
      else if (i == 10 && mode == 3) begin
        tick();
        tick();
        check_eq("perr_pre", 32'(bus.parity_err), 32'd0);
        tick();
        check_eq("perr_pulse", 32'(bus.parity_err), 32'd1);
        tick();
        check_eq("perr_post", 32'(bus.parity_err), 32'd0);
        remain = HALF_PER - 4;
      end
`endif
      repeat (remain) tick();
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF_PER) tick();
  endtask

  // Hold nextdata_n low for n cycles, comparing the head against the scoreboard each cycle.
  task automatic drain(input int n);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      bus.nextdata_n = 1'b0;
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        check_eq("rd_ready", 32'(bus.ready), 32'd1);
        check_eq("rd_data", 32'(bus.data), 32'(exp_b));
      end else begin
        check_eq("rd_empty_ready", 32'(bus.ready), 32'd0);
        check_eq("rd_empty_data", 32'(bus.data), 32'd0);
      end
      tick();
    end
    bus.nextdata_n = 1'b1;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    clrn           = 1'b0;
    ps2_clk        = 1'b1;
    ps2_data       = 1'b1;
    bus.nextdata_n = 1'b1;
    repeat (3) tick();
    clrn = 1'b1;
    tick();
    check_eq("rst_ready", 32'(bus.ready), 32'd0);
    check_eq("rst_data", 32'(bus.data), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);

    // Reset mid-frame discards the partial bits
    send_frame(8'h1C, 5, 1'b0, 1'b1, 0);
    do_reset();
    check_eq("midrst_ready", 32'(bus.ready), 32'd0);
    check_eq("midrst_data", 32'(bus.data), 32'd0);
    check_eq("midrst_ovf", 32'(bus.overflow), 32'd0);
    q.push_back(8'h1C);
    send_frame(8'h1C, 11, 1'b0, 1'b1, 0);
    drain(2);

    // Single frame with latency check, one-cycle pop
    q.push_back(8'h1C);
    send_frame(8'h1C, 11, 1'b0, 1'b1, 1);
    drain(1);
    check_eq("single_empty", 32'(bus.ready), 32'd0);

    // Burst of three, four consecutive pop cycles
    q.push_back(8'h1C);
    send_frame(8'h1C, 11, 1'b0, 1'b1, 0);
    q.push_back(8'hF0);
    send_frame(8'hF0, 11, 1'b0, 1'b1, 0);
    q.push_back(8'h1C);
    send_frame(8'h1C, 11, 1'b0, 1'b1, 0);
    drain(4);
    check_eq("burst_empty", 32'(bus.ready), 32'd0);

    // Fill past capacity
    for (int k = 1; k <= 9; k++) begin
      if (q.size() < 8) q.push_back(8'(k));
      send_frame(8'(k), 11, 1'b0, 1'b1, 0);
      if (k == 8) begin
        check_eq("fill8_ready", 32'(bus.ready), 32'd1);
        check_eq("fill8_ovf", 32'(bus.overflow), 32'd0);
      end
    end
    check_eq("fill9_ovf", 32'(bus.overflow), 32'd1);
    drain(9);
    check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Push and pop on the same edge while full
    do_reset();
    check_eq("rst2_ovf", 32'(bus.overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      q.push_back(8'(8'h11 + k));
      send_frame(8'(8'h11 + k), 11, 1'b0, 1'b1, 0);
    end
    send_frame(8'h19, 11, 1'b0, 1'b1, 2);
    q.push_back(8'h19);
    check_eq("pushpop_ovf", 32'(bus.overflow), 32'd0);
    drain(9);

    // Bad stop bit, then a timed-out partial frame, then a good frame
    send_frame(8'h1C, 11, 1'b0, 1'b0, 0);
    drain(1);
    send_frame(8'h55, 4, 1'b0, 1'b1, 0);
    repeat (TMO + 20) tick();
    q.push_back(8'h2A);
    send_frame(8'h2A, 11, 1'b0, 1'b1, 0);
    drain(2);
    check_eq("tmo_ovf", 32'(bus.overflow), 32'd0);

    // Wrong parity bit
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 11, 1'b1, 1'b1, 3);
`else
    q.push_back(8'h1C);
    send_frame(8'h1C, 11, 1'b1, 1'b1, 0);
`endif
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
